// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA byte-realignment datapath.
package dma_pkg;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned SIZE_WIDTH = 16;
    localparam int unsigned BUF_BYTES  = 8;
    localparam int unsigned CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } realign_state_e;

    // Contiguous run of `count` strobes starting at `start_lane`.
    function automatic logic [BYTE_LANES-1:0] strb_gen(input logic [1:0] start_lane,
                                                       input logic [2:0] count);
        logic [3:0] lo;
        logic [3:0] hi;
        strb_gen = '0;
        lo = {2'b00, start_lane};
        hi = lo + {1'b0, count};
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (4'(i) >= lo && 4'(i) < hi) begin
                strb_gen[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/dma_byte_buf.sv
// 8-byte shift buffer: pops from the head, then appends pushed bytes at the tail.
module dma_byte_buf
    import dma_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  clr,
    input  logic [2:0]            push_n,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [2:0]            pop_n,
    output logic [CNT_WIDTH-1:0]  buf_cnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [7:0]           buf_q [BUF_BYTES];
    logic [7:0]           buf_d [BUF_BYTES];
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] base;
    logic [CNT_WIDTH-1:0] src;
    logic [CNT_WIDTH-1:0] dst;

    always_comb begin
        base = cnt_q - {1'b0, pop_n};
        src  = '0;
        dst  = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            src      = 4'(i) + {1'b0, pop_n};
            buf_d[i] = (src < 4'(BUF_BYTES)) ? buf_q[src[2:0]] : 8'h00;
        end
        // Surviving bytes stay ahead of the newly pushed ones.
        for (int j = 0; j < BYTE_LANES; j++) begin
            dst = base + 4'(j);
            if (4'(j) < {1'b0, push_n} && dst < 4'(BUF_BYTES)) begin
                buf_d[dst[2:0]] = push_data[8*j +: 8];
            end
        end
        cnt_d = base + {1'b0, push_n};
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign buf_cnt = cnt_q;
    assign head    = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};

endmodule

// File: rtl/dma_realign.sv
// Realigns a source-aligned word stream to destination alignment, moving exactly `size` bytes.
module dma_realign
    import dma_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  start,
    input  logic [1:0]            src_off,
    input  logic [1:0]            dst_off,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [BYTE_LANES-1:0] out_strb,
    output logic                  out_last
);

    realign_state_e        state_q, state_d;
    logic [1:0]            src_off_q, src_off_d;
    logic [1:0]            dst_off_q, dst_off_d;
    logic [SIZE_WIDTH-1:0] in_left_q, in_left_d;
    logic [SIZE_WIDTH-1:0] out_left_q, out_left_d;
    logic                  first_in_q, first_in_d;
    logic                  first_out_q, first_out_d;

    logic                  run;
    logic [1:0]            skip;
    logic [2:0]            in_avail;
    logic [2:0]            in_take;
    logic [1:0]            out_lane;
    logic [2:0]            out_room;
    logic [2:0]            out_n;
    logic                  in_fire;
    logic                  out_fire;
    logic                  clr;
    logic [2:0]            push_n;
    logic [2:0]            pop_n;
    logic [DATA_WIDTH-1:0] push_data;
    logic [CNT_WIDTH-1:0]  buf_cnt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] placed;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [BYTE_LANES-1:0] strb;

    // Input trimming: leading source lanes dropped on the first word only.
    assign skip      = first_in_q ? src_off_q : 2'd0;
    assign in_avail  = 3'd4 - {1'b0, skip};
    assign in_take   = (in_left_q < SIZE_WIDTH'(in_avail)) ? in_left_q[2:0] : in_avail;
    assign push_data = in_data >> {skip, 3'b000};

    // Output need: first word starts at the destination lane, later words at lane 0.
    assign out_lane  = first_out_q ? dst_off_q : 2'd0;
    assign out_room  = 3'd4 - {1'b0, out_lane};
    assign out_n     = (out_left_q < SIZE_WIDTH'(out_room)) ? out_left_q[2:0] : out_room;

    assign run       = (state_q == RUN);
    assign in_ready  = run && (in_left_q != '0) && (buf_cnt <= 4'd4);
    assign out_valid = run && (buf_cnt >= {1'b0, out_n});
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign push_n    = in_fire ? in_take : 3'd0;
    assign pop_n     = out_fire ? out_n : 3'd0;
    assign clr       = (state_q == IDLE) && start;

    assign strb      = strb_gen(out_lane, out_n);
    assign placed    = head << {out_lane, 3'b000};
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BYTE_LANES; i++) begin
            lane_mask[8*i +: 8] = {8{strb[i]}};
        end
    end

    assign out_data  = out_valid ? (placed & lane_mask) : '0;
    assign out_strb  = out_valid ? strb : '0;
    assign out_last  = out_valid && (out_left_q == SIZE_WIDTH'(out_n));
    assign busy      = run;
    assign done      = (state_q == FIN);

    dma_byte_buf u_buf (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .clr       (clr),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .buf_cnt   (buf_cnt),
        .head      (head)
    );

    always_comb begin
        state_d     = state_q;
        src_off_d   = src_off_q;
        dst_off_d   = dst_off_q;
        in_left_d   = in_left_q;
        out_left_d  = out_left_q;
        first_in_d  = first_in_q;
        first_out_d = first_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_off_d   = src_off;
                    dst_off_d   = dst_off;
                    in_left_d   = size;
                    out_left_d  = size;
                    first_in_d  = 1'b1;
                    first_out_d = 1'b1;
                    state_d     = (size != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (in_fire) begin
                    in_left_d  = in_left_q - SIZE_WIDTH'(in_take);
                    first_in_d = 1'b0;
                end
                if (out_fire) begin
                    out_left_d  = out_left_q - SIZE_WIDTH'(out_n);
                    first_out_d = 1'b0;
                    if (out_last) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            src_off_q   <= '0;
            dst_off_q   <= '0;
            in_left_q   <= '0;
            out_left_q  <= '0;
            first_in_q  <= 1'b0;
            first_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_off_q   <= src_off_d;
            dst_off_q   <= dst_off_d;
            in_left_q   <= in_left_d;
            out_left_q  <= out_left_d;
            first_in_q  <= first_in_d;
            first_out_q <= first_out_d;
        end
    end

endmodule

// File: tb/tb_dma_realign.sv
// Scoreboard bench for dma_realign: byte-stream reference model vs. observed output words.
module tb_dma_realign;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start;
    logic [1:0]  src_off;
    logic [1:0]  dst_off;
    logic [15:0] size;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] src_words[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          last_hs_cyc = -10;
    int          done_cnt = 0;

    dma_realign dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .start     (start),
        .src_off   (src_off),
        .dst_off   (dst_off),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_last  (out_last)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    always @(negedge CLK) if (RSTN && done) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every output handshake is compared with the head of the scoreboard.
    always @(negedge CLK) begin
        if (RSTN && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got data 0x%08h strb %b with empty scoreboard",
                         out_data, out_strb);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (out_data !== e.data || out_strb !== e.strb || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL out_word: got %08h/%b/%b, expected %08h/%b/%b",
                             out_data, out_strb, out_last, e.data, e.strb, e.last);
                end
                if (out_last) last_hs_cyc = cycle;
            end
        end
    end

    // Reference model: pick the byte window from the source address space, lay it
    // into the destination address space word by word.
    task automatic build_expected(input int so, input int dof, input int sz);
        logic [7:0] stream[$];
        int nout;
        for (int i = 0; i < sz; i++) begin
            logic [31:0] w;
            w = src_words[(so + i) / 4];
            stream.push_back(w[8*((so + i) % 4) +: 8]);
        end
        nout = (dof + sz + 3) / 4;
        for (int w = 0; w < nout; w++) begin
            exp_t e;
            e.data = '0;
            e.strb = '0;
            for (int l = 0; l < 4; l++) begin
                int p;
                p = 4 * w + l - dof;
                if (p >= 0 && p < sz) begin
                    e.data[8*l +: 8] = stream[p];
                    e.strb[l] = 1'b1;
                end
            end
            e.last = (w == nout - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_random(input int so, input int sz);
        src_words.delete();
        for (int i = 0; i < (so + sz + 3) / 4; i++) src_words.push_back($urandom);
    endtask

    // Runs one transfer; caller is positioned just after a rising edge.
    task automatic run_xfer(input int so, input int dof, input int sz, input int pin,
                            input int pout, input int hold, input int abort_n,
                            input string name);
        int idx = 0;
        int cyc = 0;
        int outs = 0;
        int nw;
        bit got_done = 0;
        nw = src_words.size();
        build_expected(so, dof, sz);
        start   = 1'b1;
        src_off = 2'(so);
        dst_off = 2'(dof);
        size    = 16'(sz);
        @(posedge CLK);
        #1 start = 1'b0;
        while (!got_done && cyc < 2000) begin
            in_valid  = (idx < nw) && ($urandom_range(99) < pin);
            in_data   = in_valid ? src_words[idx] : $urandom;
            out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pout);
            @(negedge CLK);
            if (cyc == 0) chk({name, "_busy"}, 32'(busy), 32'd1);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) outs++;
            if (hold != 0 && cyc == hold - 1) begin
                chk({name, "_bp_accepted"}, 32'(idx), 32'd2);
                chk({name, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            end
            if (abort_n != 0 && outs >= abort_n) begin
                int dcnt;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                #2 RSTN = 1'b0;
                #1;
                chk({name, "_rst_ctl"}, 32'({busy, done, in_ready, out_valid, out_last, out_strb}), 32'd0);
                chk({name, "_rst_data"}, out_data, 32'd0);
                exp_q.delete();
                dcnt = done_cnt;
                repeat (3) @(posedge CLK);
                #1 RSTN = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                chk({name, "_no_done"}, 32'(done_cnt), 32'(dcnt));
                chk({name, "_idle_busy"}, 32'(busy), 32'd0);
                return;
            end
            if (done) begin
                got_done = 1;
                chk({name, "_done_timing"}, 32'(cycle), 32'(last_hs_cyc + 1));
                chk({name, "_done_busy"}, 32'(busy), 32'd0);
            end
            @(posedge CLK);
            #1 cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!got_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
        end
        chk({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_in_consumed"}, 32'(idx), 32'(nw));
        exp_q.delete();
    endtask

    initial begin
        RSTN      = 1'b0;
        start     = 1'b0;
        src_off   = '0;
        dst_off   = '0;
        size      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ctl", 32'({busy, done, in_ready, out_valid, out_last, out_strb}), 32'd0);
        chk("reset_data", out_data, 32'd0);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        src_words = '{32'h03020100, 32'h07060504};
        run_xfer(0, 0, 8, 100, 100, 0, 0, "aligned");
        src_words = '{32'h03020100, 32'h07060504};
        run_xfer(1, 0, 5, 100, 100, 0, 0, "src_off");
        src_words = '{32'hDDCCBBAA};
        run_xfer(0, 3, 4, 100, 100, 0, 0, "dst_off");

        // Zero-size transfer: straight to done, no handshakes.
        start = 1'b1;
        size  = 16'd0;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hs", 32'({busy, in_ready, out_valid}), 32'd0);
        @(negedge CLK);
        chk("zero_done_clear", 32'({done, in_ready, out_valid}), 32'd0);
        @(posedge CLK);
        #1;

        fill_random(0, 16);
        run_xfer(0, 0, 16, 100, 100, 10, 0, "backpressure");

        fill_random(0, 8);
        run_xfer(0, 0, 8, 100, 100, 0, 1, "reset_mid");
        fill_random(0, 4);
        run_xfer(0, 0, 4, 100, 100, 0, 0, "after_reset");

        for (int t = 0; t < 40; t++) begin
            int so;
            int dof;
            int sz;
            so  = $urandom_range(3);
            dof = $urandom_range(3);
            sz  = $urandom_range(40, 1);
            fill_random(so, sz);
            run_xfer(so, dof, sz, $urandom_range(100, 30), $urandom_range(100, 30), 0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
